// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / logical / arithmetic / rotate, single-step or burst.
// Define UNIV_SHIFT_CARRY_EN to add the carry output (last bit shifted out).
module univ_shift_reg #(
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 4,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] PO,
  output logic             busy,
`ifdef UNIV_SHIFT_CARRY_EN
  output logic             done,
  output logic             carry
`else
  output logic             done
`endif
);

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_LSH  = 2'b01;
  localparam logic [1:0] M_ASH  = 2'b10;
  localparam logic [1:0] M_ROT  = 2'b11;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t r_state;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0]   w_ones;
  logic               w_fill;
  logic [WIDTH-1:0]   w_shl;
  logic [WIDTH-1:0]   w_shr;
  logic [2*WIDTH-1:0] w_rotl_x;
  logic [2*WIDTH-1:0] w_rotr_x;
  logic [WIDTH-1:0]   w_next;
`ifdef UNIV_SHIFT_CARRY_EN
  logic [WIDTH:0]     w_cl_x;
  logic [WIDTH:0]     w_cr_x;
  logic               w_cout;
  logic               w_cupd;
`endif

  // Arithmetic mode fills with the sign on right shifts, zero on left.
  always_comb begin
    w_ones = '1;
    if (mode == M_ASH) begin
      w_fill = dir ? PO[WIDTH-1] : 1'b0;
    end else begin
      w_fill = sin;
    end
    w_shl = (PO << amt)
          | (~(w_ones << amt) & {WIDTH{w_fill}});
    w_shr = (PO >> amt)
          | (~(w_ones >> amt) & {WIDTH{w_fill}});
    w_rotl_x = {PO, PO} << amt;
    w_rotr_x = {PO, PO} >> amt;
    w_next = PO;
    unique case (mode)
      M_HOLD: w_next = PO;
      M_LSH,
      M_ASH:  w_next = dir ? w_shr : w_shl;
      M_ROT:  w_next = dir ? w_rotr_x[WIDTH-1:0]
                           : w_rotl_x[2*WIDTH-1:WIDTH];
      default: w_next = PO;
    endcase
  end

`ifdef UNIV_SHIFT_CARRY_EN
  // Bit WIDTH / bit 0 of the widened shift is the last bit pushed out.
  always_comb begin
    w_cl_x = {1'b0, PO} << amt;
    w_cr_x = {PO, 1'b0} >> amt;
    w_cout = dir ? w_cr_x[0] : w_cl_x[WIDTH];
    w_cupd = ((mode == M_LSH) || (mode == M_ASH))
           && (amt != '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      PO      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      r_cnt   <= '0;
      r_state <= IDLE;
`ifdef UNIV_SHIFT_CARRY_EN
      carry   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (set) begin
        PO      <= '1;
        busy    <= 1'b0;
        r_cnt   <= '0;
        r_state <= IDLE;
      end else if (load) begin
        PO      <= load_value;
        busy    <= 1'b0;
        r_cnt   <= '0;
        r_state <= IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (start) begin
              if (count == '0) begin
                done <= 1'b1;
              end else begin
                r_cnt   <= count;
                busy    <= 1'b1;
                r_state <= RUN;
              end
            end else if (en) begin
              PO <= w_next;
`ifdef UNIV_SHIFT_CARRY_EN
              if (w_cupd) carry <= w_cout;
`endif
            end
          end
          RUN: begin
            PO    <= w_next;
            r_cnt <= r_cnt - CNT_W'(1);
`ifdef UNIV_SHIFT_CARRY_EN
            if (w_cupd) carry <= w_cout;
`endif
            if (r_cnt == CNT_W'(1)) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8, CNT_W=4).
// Expected values are spec constants queued with each stimulus cycle.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst, set, load;
  logic [7:0] load_value;
  logic [1:0] mode;
  logic       dir;
  logic [2:0] amt;
  logic       sin, en, start;
  logic [3:0] count;
  logic [7:0] PO;
  logic       busy, done;
`ifdef UNIV_SHIFT_CARRY_EN
  logic       carry;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst, set, load;
    logic [7:0] lv;
    logic [1:0] mode;
    logic       dir;
    logic [2:0] amt;
    logic       sin, en, start;
    logic [3:0] count;
  } stim_t;

  typedef struct {
    string      nm;
    logic [7:0] po;
    logic       busy, done, c;
  } exp_t;

  stim_t sq[$];
  exp_t  xq[$];
  stim_t s;
  exp_t  e;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .set(set), .load(load),
    .load_value(load_value), .mode(mode), .dir(dir),
    .amt(amt), .sin(sin), .en(en), .start(start),
    .count(count), .PO(PO), .busy(busy),
`ifdef UNIV_SHIFT_CARRY_EN
    .done(done), .carry(carry)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  function automatic void st(
    logic r, logic st_, logic ld, logic [7:0] lv,
    logic [1:0] m, logic d, logic [2:0] a, logic si,
    logic e_, logic go, logic [3:0] c);
    stim_t t;
    t.rst = r; t.set = st_; t.load = ld; t.lv = lv;
    t.mode = m; t.dir = d; t.amt = a; t.sin = si;
    t.en = e_; t.start = go; t.count = c;
    sq.push_back(t);
  endfunction

  function automatic void ex(string nm, logic [7:0] po,
    logic b, logic d, logic c);
    exp_t t;
    t.nm = nm; t.po = po; t.busy = b; t.done = d; t.c = c;
    xq.push_back(t);
  endfunction

  task automatic drv(input stim_t t);
    rst = t.rst; set = t.set; load = t.load;
    load_value = t.lv; mode = t.mode; dir = t.dir;
    amt = t.amt; sin = t.sin; en = t.en;
    start = t.start; count = t.count;
  endtask

  task automatic test_reset();
    st(1,0,0,8'h00, 2'b00,0,0,0, 0,0,0); ex("rst", 8'h00,0,0,0);
    st(0,0,0,8'h00, 2'b00,0,0,0, 0,0,0); ex("rst_idle", 8'h00,0,0,0);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drv(s);
      @(posedge clk); #1;
      e = xq.pop_front();
      n_cmp++;
      if ({PO, busy, done} !== {e.po, e.busy, e.done}) begin
        n_fail++;
        $display("FAIL %s: got PO=%h busy=%b done=%b want PO=%h busy=%b done=%b",
                 e.nm, PO, busy, done, e.po, e.busy, e.done);
      end
`ifdef UNIV_SHIFT_CARRY_EN
      n_cmp++;
      if (carry !== e.c) begin
        n_fail++;
        $display("FAIL %s_carry: got %b want %b", e.nm, carry, e.c);
      end
`endif
    end
  endtask

  task automatic test_shift();
    st(0,0,1,8'hA5, 2'b00,0,0,0, 0,0,0); ex("ld_a5", 8'hA5,0,0,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 1,0,0); ex("lsl1_a", 8'h4A,0,0,1);
    st(0,0,0,8'h00, 2'b01,0,1,0, 1,0,0); ex("lsl1_b", 8'h94,0,0,0);
    st(0,0,0,8'h00, 2'b01,0,2,1, 1,0,0); ex("lsl2_sin1", 8'h53,0,0,0);
    st(0,0,0,8'h00, 2'b01,1,3,1, 1,0,0); ex("lsr3_sin1", 8'hEA,0,0,0);
    st(0,0,0,8'h00, 2'b00,0,3,1, 1,0,0); ex("hold", 8'hEA,0,0,0);
    st(0,0,0,8'h00, 2'b01,0,0,1, 1,0,0); ex("amt0", 8'hEA,0,0,0);
    st(0,1,1,8'h00, 2'b01,0,1,0, 1,1,3); ex("set_over_ld", 8'hFF,0,0,0);
    st(0,0,1,8'h96, 2'b00,0,0,0, 0,0,0); ex("ld_96", 8'h96,0,0,0);
    st(0,0,0,8'h00, 2'b10,1,2,0, 1,0,0); ex("asr2", 8'hE5,0,0,1);
    st(0,0,0,8'h00, 2'b10,0,1,1, 1,0,0); ex("asl1", 8'hCA,0,0,1);
    st(0,0,1,8'h81, 2'b00,0,0,0, 0,0,0); ex("ld_81", 8'h81,0,0,1);
    st(0,0,0,8'h00, 2'b11,1,3,0, 1,0,0); ex("rotr3", 8'h30,0,0,1);
    st(0,0,0,8'h00, 2'b11,0,4,0, 1,0,0); ex("rotl4", 8'h03,0,0,1);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drv(s);
      @(posedge clk); #1;
      e = xq.pop_front();
      n_cmp++;
      if ({PO, busy, done} !== {e.po, e.busy, e.done}) begin
        n_fail++;
        $display("FAIL %s: got PO=%h busy=%b done=%b want PO=%h busy=%b done=%b",
                 e.nm, PO, busy, done, e.po, e.busy, e.done);
      end
`ifdef UNIV_SHIFT_CARRY_EN
      n_cmp++;
      if (carry !== e.c) begin
        n_fail++;
        $display("FAIL %s_carry: got %b want %b", e.nm, carry, e.c);
      end
`endif
    end
  endtask

  task automatic test_burst();
    st(0,0,1,8'h01, 2'b00,0,0,0, 0,0,0); ex("b_ld", 8'h01,0,0,1);
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,1,3); ex("b_e0", 8'h01,1,0,1);
    st(0,0,0,8'h00, 2'b01,0,1,0, 1,0,0); ex("b_e1", 8'h02,1,0,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,0,0); ex("b_e2", 8'h04,1,0,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,0,0); ex("b_e3", 8'h08,0,1,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,0,0); ex("b_after", 8'h08,0,0,0);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drv(s);
      @(posedge clk); #1;
      e = xq.pop_front();
      n_cmp++;
      if ({PO, busy, done} !== {e.po, e.busy, e.done}) begin
        n_fail++;
        $display("FAIL %s: got PO=%h busy=%b done=%b want PO=%h busy=%b done=%b",
                 e.nm, PO, busy, done, e.po, e.busy, e.done);
      end
`ifdef UNIV_SHIFT_CARRY_EN
      n_cmp++;
      if (carry !== e.c) begin
        n_fail++;
        $display("FAIL %s_carry: got %b want %b", e.nm, carry, e.c);
      end
`endif
    end
  endtask

  task automatic test_abort();
    st(0,0,1,8'h01, 2'b00,0,0,0, 0,0,0); ex("a_ld", 8'h01,0,0,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,1,5); ex("a_e0", 8'h01,1,0,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,0,0); ex("a_e1", 8'h02,1,0,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,1,1); ex("a_e2", 8'h04,1,0,0);
    st(0,0,1,8'h3C, 2'b01,0,1,0, 0,0,0); ex("a_load", 8'h3C,0,0,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,0,0); ex("a_nodone", 8'h3C,0,0,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,1,2); ex("r_e0", 8'h3C,1,0,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 1,1,7); ex("r_e1", 8'h78,1,0,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,0,0); ex("r_e2", 8'hF0,0,1,0);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drv(s);
      @(posedge clk); #1;
      e = xq.pop_front();
      n_cmp++;
      if ({PO, busy, done} !== {e.po, e.busy, e.done}) begin
        n_fail++;
        $display("FAIL %s: got PO=%h busy=%b done=%b want PO=%h busy=%b done=%b",
                 e.nm, PO, busy, done, e.po, e.busy, e.done);
      end
`ifdef UNIV_SHIFT_CARRY_EN
      n_cmp++;
      if (carry !== e.c) begin
        n_fail++;
        $display("FAIL %s_carry: got %b want %b", e.nm, carry, e.c);
      end
`endif
    end
  endtask

  task automatic test_zero_set_rst();
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,1,0); ex("z_done", 8'hF0,0,1,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,0,0); ex("z_after", 8'hF0,0,0,0);
    st(0,0,0,8'h00, 2'b01,1,1,0, 0,1,4); ex("s_e0", 8'hF0,1,0,0);
    st(0,0,0,8'h00, 2'b01,1,1,0, 0,0,0); ex("s_e1", 8'h78,1,0,0);
    st(0,1,0,8'h00, 2'b01,1,1,0, 0,0,0); ex("s_set", 8'hFF,0,0,0);
    st(0,0,0,8'h00, 2'b01,1,1,0, 0,0,0); ex("s_nodone", 8'hFF,0,0,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,1,4); ex("q_e0", 8'hFF,1,0,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,0,0); ex("q_e1", 8'hFE,1,0,1);
    st(1,1,1,8'h55, 2'b01,0,1,0, 1,1,4); ex("q_rst", 8'h00,0,0,0);
    st(0,0,0,8'h00, 2'b01,0,1,0, 0,0,0); ex("q_after", 8'h00,0,0,0);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drv(s);
      @(posedge clk); #1;
      e = xq.pop_front();
      n_cmp++;
      if ({PO, busy, done} !== {e.po, e.busy, e.done}) begin
        n_fail++;
        $display("FAIL %s: got PO=%h busy=%b done=%b want PO=%h busy=%b done=%b",
                 e.nm, PO, busy, done, e.po, e.busy, e.done);
      end
`ifdef UNIV_SHIFT_CARRY_EN
      n_cmp++;
      if (carry !== e.c) begin
        n_fail++;
        $display("FAIL %s_carry: got %b want %b", e.nm, carry, e.c);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; set = 1'b0; load = 1'b0; load_value = '0;
    mode = '0; dir = 1'b0; amt = '0; sin = 1'b0;
    en = 1'b0; start = 1'b0; count = '0;
    test_reset();
    test_shift();
    test_burst();
    test_abort();
    test_zero_set_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width; it must be a power of two and at least 4.
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning burst count width.
REQ-003 The block SHALL use derived localparam AMT_W = clog2(WIDTH).
REQ-004 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: set  input  1  synchronous; forces PO to all ones.
REQ-007 Port: load  input  1  synchronous parallel load.
REQ-008 Port: load_value  input  WIDTH  parallel load data.
REQ-009 Port: mode  input  2  operation: 00 hold, 01 logical shift, 10 arithmetic shift, 11 rotate.
REQ-010 Port: dir  input  1  direction: 0 left, 1 right.
REQ-011 Port: amt  input  AMT_W  shift amount per operation, 0..WIDTH-1.
REQ-012 Port: sin  input  1  fill bit for vacated positions in logical shifts.
REQ-013 Port: en  input  1  performs one operation this edge when idle.
REQ-014 Port: start  input  1  begins a burst.
REQ-015 Port: count  input  CNT_W  number of operations in a burst.
REQ-016 Port: PO  output  WIDTH  register contents.
REQ-017 Port: busy  output  1  a burst is in progress.
REQ-018 Port: done  output  1  one-cycle pulse marking burst completion.

Function
REQ-019 Priority per edge SHALL be: rst > set > load > burst step > en > hold.
REQ-020 set SHALL drive PO to all ones; load SHALL drive PO to load_value; both take effect in one cycle and abort any burst (busy=0, no done pulse).
REQ-021 Logical shift SHALL move PO by amt positions in direction dir, filling every vacated bit with sin.
REQ-022 Arithmetic right shift SHALL fill vacated bits with the pre-shift PO[WIDTH-1]; arithmetic left shift SHALL behave as logical left with 0 fill (sin ignored).
REQ-023 Rotate SHALL recirculate bits by amt positions in direction dir with no loss.
REQ-024 With amt=0 or mode=00, an operation SHALL leave PO unchanged.
REQ-025 The block SHALL have state machine states IDLE and RUN; a start seen in IDLE at edge E0 SHALL latch count and enter RUN with no shift at E0.
REQ-026 In RUN, the block SHALL perform one operation (current mode, dir, amt, sin) per edge at E1..EN, decrementing an internal counter each edge.
REQ-027 busy SHALL be 1 from after E0 through EN, then return to IDLE; done SHALL be 1 only for the cycle after EN.
REQ-028 A start with count=0 SHALL cause no shift, keep busy at 0, and pulse done for the cycle after E0.
REQ-029 start while busy SHALL be ignored; en while busy SHALL be ignored.
REQ-030 Mode, dir, amt and sin SHALL be sampled live each burst step (not latched at start).

Reset
REQ-031 rst SHALL set PO=0, busy=0, done=0, the counter to 0 and the state to IDLE at the next edge, overriding all other inputs including a burst in progress.

Configuration
REQ-032 With macro UNIV_SHIFT_CARRY_EN defined, the block SHALL add output port carry (1 bit) holding the last bit shifted out by the most recent nonzero-amt logical or arithmetic shift (left: pre-shift PO[WIDTH-amt]; right: pre-shift PO[amt-1]).
REQ-033 carry SHALL be 0 after reset, SHALL be unchanged by rotate, hold, amt=0, set or load, and SHALL be absent when the macro is undefined, with all other behaviour identical.

Verification (WIDTH=8, CNT_W=4)
REQ-034 The bench SHALL check: rst=1 for 1 edge -> PO=8'h00, busy=0, done=0.
REQ-035 The bench SHALL check: load 8'hA5, then en=1, mode=01, dir=0, amt=1, sin=0 for 2 edges -> PO=8'h4A then 8'h94 (carry 1 then 0 with macro).
REQ-036 The bench SHALL check: load 8'h96, then mode=10, dir=1, amt=2, en 1 edge -> PO=8'hE5; load 8'h81, then mode=11, dir=1, amt=3 -> PO=8'h30.
REQ-037 The bench SHALL check: load 8'h01, then start with count=3, mode=01, dir=0, amt=1 -> busy for 3 cycles, PO 02/04/08, done high one cycle with PO=8'h08, busy=0.
REQ-038 The bench SHALL check: burst count=5 from 8'h01, then load 8'h3C after 2 steps -> PO=8'h3C, busy=0, no done pulse; a start during a burst has no effect.
REQ-039 The bench SHALL check: start with count=0 -> done pulse with PO unchanged; set during RUN -> PO=8'hFF, busy=0; rst during RUN -> all outputs zero.
